// File: rtl/simultaneous_to_sequential_reg_ps_first_pkg.sv
// Shared types and helpers for the parallel-in / word-serial-out shifter.
// Holds the FSM encoding, a constant clog2 and the DIRECTION-aware word slot mapping.
package simultaneous_to_sequential_reg_ps_first_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Physical slot of logical word k: low-first when direction > 0, mirrored otherwise.
   function automatic int word_slot(input int k, input int n, input int direction);
      return (direction > 0) ? k : (n - 1 - k);
   endfunction

endpackage

// File: rtl/simultaneous_to_sequential_word_mux.sv
// Combinational SHIFT_LEN:1 word selector; i_sel names the logical word, DIRECTION maps it to a slot.
// Zero latency, no flow control of its own.
module simultaneous_to_sequential_word_mux
   import simultaneous_to_sequential_reg_ps_first_pkg::*;
#(
   parameter int DIRECTION = 1,
   parameter int SHIFT_LEN = 4,
   parameter int BIT_WIDTH = 2,
   parameter int CNT_W     = 2
) (
   input  logic [BIT_WIDTH*SHIFT_LEN-1:0] i_vec,
   input  logic [CNT_W-1:0]               i_sel,
   output logic [BIT_WIDTH-1:0]           o_word
);

   always_comb begin
      o_word = '0;
      for (int k = 0; k < SHIFT_LEN; k++) begin
         if (i_sel == CNT_W'(k)) begin
            o_word = i_vec[word_slot(k, SHIFT_LEN, DIRECTION)*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

endmodule

// File: rtl/simultaneous_to_sequential_reg_ps_first.sv
// Parallel-in, word-serial-out shifter: word 0 bypasses the register in the load cycle (0-cycle latency),
// one word per out_valid & in_ctr_sh_en; stalls hold the word, loads are only taken in IDLE or on the last word.
module simultaneous_to_sequential_reg_ps_first
   import simultaneous_to_sequential_reg_ps_first_pkg::*;
#(
   parameter int DIRECTION = 1,
   parameter int SHIFT_LEN = 4,
   parameter int BIT_WIDTH = 2
) (
   input  logic                           clk,
   input  logic                           in_ctr_Arst_n,
   input  logic                           in_ctr_Srst,
   input  logic                           in_ctr_load,
   input  logic                           in_ctr_sh_en,
   input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
   output logic                           out_load_ack,
   output logic [BIT_WIDTH-1:0]           out,
   output logic                           out_valid,
   output logic                           out_first,
   output logic                           out_last
);

   localparam int CNT_W = clog2(SHIFT_LEN);
   localparam int VEC_W = BIT_WIDTH * SHIFT_LEN;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SHIFT_LEN - 1);

   generate
      if (SHIFT_LEN < 2) begin : g_bad_len
         $error("SHIFT_LEN must be at least 2");
      end
   endgenerate

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_idx, w_idx_nxt;
   logic [VEC_W-1:0]   r_vec, w_vec_nxt;

   logic               w_is_idle;
   logic               w_at_last;
   logic               w_load_ack;
   logic               w_valid;
   logic [VEC_W-1:0]   w_mux_vec;
   logic [CNT_W-1:0]   w_mux_sel;
   logic [BIT_WIDTH-1:0] w_word;

   assign w_is_idle  = (r_state == ST_IDLE);
   assign w_at_last  = (r_idx == LAST_IDX);
   assign w_load_ack = in_ctr_load & ~in_ctr_Srst &
                       (w_is_idle | (~w_is_idle & in_ctr_sh_en & w_at_last));

   // In IDLE the mux looks straight at the input bus so word 0 leaves in the load cycle.
   assign w_mux_vec = w_is_idle ? in : r_vec;
   assign w_mux_sel = w_is_idle ? '0 : r_idx;

   simultaneous_to_sequential_word_mux #(
      .DIRECTION (DIRECTION),
      .SHIFT_LEN (SHIFT_LEN),
      .BIT_WIDTH (BIT_WIDTH),
      .CNT_W     (CNT_W)
   ) u_word_mux (
      .i_vec  (w_mux_vec),
      .i_sel  (w_mux_sel),
      .o_word (w_word)
   );

   always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
      if (!in_ctr_Arst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_vec   <= w_vec_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_vec_nxt   = r_vec;
      if (in_ctr_Srst) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = '0;
         w_vec_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_ctr_load) begin
                  w_state_nxt = ST_SHIFT;
                  w_vec_nxt   = in;
                  w_idx_nxt   = in_ctr_sh_en ? CNT_W'(1) : '0;
               end
            end
            ST_SHIFT: begin
               if (in_ctr_sh_en) begin
                  if (!w_at_last) begin
                     w_idx_nxt = r_idx + 1'b1;
                  end else if (in_ctr_load) begin
                     w_vec_nxt = in;
                     w_idx_nxt = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_idx_nxt   = '0;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are forced low while async reset is held, independent of the load request.
   assign w_valid      = w_is_idle ? (in_ctr_load & ~in_ctr_Srst) : 1'b1;
   assign out_valid    = in_ctr_Arst_n & w_valid;
   assign out          = out_valid ? w_word : '0;
   assign out_first    = out_valid & (w_is_idle | (r_idx == '0));
   assign out_last     = out_valid & ~w_is_idle & w_at_last;
   assign out_load_ack = in_ctr_Arst_n & w_load_ack;

endmodule

// File: tb/tb_simultaneous_to_sequential_reg_ps_first.sv
// Directed bench for the PISO shifter: a cycle table for streaming/stall/back-to-back,
// plus hand sequences for DIRECTION=0, synchronous clear and async reset.
module tb_simultaneous_to_sequential_reg_ps_first;

   logic        clk;
   logic        arst_n;
   logic        srst;
   logic        load;
   logic        sh_en;
   logic [15:0] din;

   logic        f_ack, f_vld, f_first, f_last;
   logic [3:0]  f_out;
   logic        r_ack, r_vld, r_first, r_last;
   logic [3:0]  r_out;

   int n_run;
   int n_fail;

   simultaneous_to_sequential_reg_ps_first #(
      .DIRECTION (1), .SHIFT_LEN (4), .BIT_WIDTH (4)
   ) u_dut (
      .clk           (clk),
      .in_ctr_Arst_n (arst_n),
      .in_ctr_Srst   (srst),
      .in_ctr_load   (load),
      .in_ctr_sh_en  (sh_en),
      .in            (din),
      .out_load_ack  (f_ack),
      .out           (f_out),
      .out_valid     (f_vld),
      .out_first     (f_first),
      .out_last      (f_last)
   );

   simultaneous_to_sequential_reg_ps_first #(
      .DIRECTION (0), .SHIFT_LEN (4), .BIT_WIDTH (4)
   ) u_dut_rev (
      .clk           (clk),
      .in_ctr_Arst_n (arst_n),
      .in_ctr_Srst   (srst),
      .in_ctr_load   (load),
      .in_ctr_sh_en  (sh_en),
      .in            (din),
      .out_load_ack  (r_ack),
      .out           (r_out),
      .out_valid     (r_vld),
      .out_first     (r_first),
      .out_last      (r_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        load;
      logic        sh;
      logic        srst;
      logic [15:0] din;
      logic        ack;
      logic        vld;
      logic [3:0]  dout;
      logic        first;
      logic        last;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(input logic l, input logic s, input logic c, input logic [15:0] d,
                               input logic a, input logic v, input logic [3:0] o,
                               input logic fi, input logic la);
      vec_t t;
      t.load = l; t.sh = s; t.srst = c; t.din = d;
      t.ack = a; t.vld = v; t.dout = o; t.first = fi; t.last = la;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic l, input logic s, input logic c, input logic [15:0] d);
      @(negedge clk);
      load = l; sh_en = s; srst = c; din = d;
      #1;
   endtask

   task automatic chk_fwd(input string tag, input logic a, input logic v, input logic [3:0] o,
                          input logic fi, input logic la);
      chk({tag, " ack"},   16'(f_ack),   16'(a));
      chk({tag, " valid"}, 16'(f_vld),   16'(v));
      chk({tag, " out"},   16'(f_out),   16'(o));
      chk({tag, " first"}, 16'(f_first), 16'(fi));
      chk({tag, " last"},  16'(f_last),  16'(la));
   endtask

   task automatic chk_rev(input string tag, input logic a, input logic v, input logic [3:0] o,
                          input logic fi, input logic la);
      chk({tag, " ack"},   16'(r_ack),   16'(a));
      chk({tag, " valid"}, 16'(r_vld),   16'(v));
      chk({tag, " out"},   16'(r_out),   16'(o));
      chk({tag, " first"}, 16'(r_first), 16'(fi));
      chk({tag, " last"},  16'(r_last),  16'(la));
   endtask

   logic [3:0] rev_exp [4];

   initial begin
      n_run = 0; n_fail = 0;
      arst_n = 1'b0; srst = 1'b0; load = 1'b0; sh_en = 1'b0; din = 16'h0000;

      // streaming
      tbl[0]  = mk(1,1,0,16'hDCBA, 1,1,4'hA,1,0);
      tbl[1]  = mk(0,1,0,16'hDCBA, 0,1,4'hB,0,0);
      tbl[2]  = mk(0,1,0,16'hDCBA, 0,1,4'hC,0,0);
      tbl[3]  = mk(0,1,0,16'hDCBA, 0,1,4'hD,0,1);
      tbl[4]  = mk(0,0,0,16'hDCBA, 0,0,4'h0,0,0);
      // stall
      tbl[5]  = mk(1,0,0,16'hDCBA, 1,1,4'hA,1,0);
      tbl[6]  = mk(0,0,0,16'h0000, 0,1,4'hA,1,0);
      tbl[7]  = mk(0,0,0,16'h0000, 0,1,4'hA,1,0);
      tbl[8]  = mk(0,0,0,16'h0000, 0,1,4'hA,1,0);
      tbl[9]  = mk(0,1,0,16'h0000, 0,1,4'hA,1,0);
      tbl[10] = mk(0,0,0,16'h0000, 0,1,4'hB,0,0);
      tbl[11] = mk(0,1,0,16'h0000, 0,1,4'hB,0,0);
      tbl[12] = mk(0,0,0,16'h0000, 0,1,4'hC,0,0);
      tbl[13] = mk(0,1,0,16'h0000, 0,1,4'hC,0,0);
      tbl[14] = mk(0,0,0,16'h0000, 0,1,4'hD,0,1);
      tbl[15] = mk(0,0,0,16'h0000, 0,1,4'hD,0,1);
      tbl[16] = mk(0,1,0,16'h0000, 0,1,4'hD,0,1);
      tbl[17] = mk(0,0,0,16'h0000, 0,0,4'h0,0,0);
      // back-to-back, with an early load that must be refused
      tbl[18] = mk(1,1,0,16'hDCBA, 1,1,4'hA,1,0);
      tbl[19] = mk(1,1,0,16'h4321, 0,1,4'hB,0,0);
      tbl[20] = mk(0,1,0,16'h4321, 0,1,4'hC,0,0);
      tbl[21] = mk(1,1,0,16'h4321, 1,1,4'hD,0,1);
      tbl[22] = mk(0,1,0,16'h0000, 0,1,4'h1,1,0);
      tbl[23] = mk(0,1,0,16'h0000, 0,1,4'h2,0,0);
      tbl[24] = mk(0,1,0,16'h0000, 0,1,4'h3,0,0);
      tbl[25] = mk(0,1,0,16'h0000, 0,1,4'h4,0,1);
      tbl[26] = mk(0,0,0,16'h0000, 0,0,4'h0,0,0);

      // reset state, including a load request held during reset
      #1;
      chk_fwd("reset", 0, 0, 4'h0, 0, 0);
      load = 1'b1; sh_en = 1'b1; din = 16'hDCBA;
      #1;
      chk_fwd("reset_load", 0, 0, 4'h0, 0, 0);
      load = 1'b0; sh_en = 1'b0; din = 16'h0000;
      @(negedge clk);
      arst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         cyc(tbl[i].load, tbl[i].sh, tbl[i].srst, tbl[i].din);
         chk_fwd($sformatf("tbl%0d", i), tbl[i].ack, tbl[i].vld, tbl[i].dout, tbl[i].first, tbl[i].last);
      end

      // DIRECTION=0: D, C, B, A
      rev_exp[0] = 4'hD; rev_exp[1] = 4'hC; rev_exp[2] = 4'hB; rev_exp[3] = 4'hA;
      for (int i = 0; i < 4; i++) begin
         cyc((i == 0), 1'b1, 1'b0, 16'hDCBA);
         chk_rev($sformatf("rev%0d", i), (i == 0), 1'b1, rev_exp[i], (i == 0), (i == 3));
      end
      cyc(0, 0, 0, 16'h0000);
      chk_rev("rev_idle", 0, 0, 4'h0, 0, 0);

      // synchronous clear in the C cycle beats load and sh_en
      cyc(1, 1, 0, 16'hDCBA);
      chk_fwd("srst_a", 1, 1, 4'hA, 1, 0);
      cyc(0, 1, 0, 16'hDCBA);
      chk_fwd("srst_b", 0, 1, 4'hB, 0, 0);
      cyc(1, 1, 1, 16'hDCBA);
      chk_fwd("srst_c", 0, 1, 4'hC, 0, 0);
      cyc(0, 0, 0, 16'h0000);
      chk_fwd("srst_after", 0, 0, 4'h0, 0, 0);
      cyc(1, 1, 0, 16'h4321);
      chk_fwd("srst_reload", 1, 1, 4'h1, 1, 0);
      cyc(0, 1, 0, 16'h0000);
      chk_fwd("srst_w1", 0, 1, 4'h2, 0, 0);
      cyc(0, 1, 0, 16'h0000);
      cyc(0, 1, 0, 16'h0000);
      chk_fwd("srst_w3", 0, 1, 4'h4, 0, 1);
      cyc(0, 0, 0, 16'h0000);
      chk_fwd("srst_idle", 0, 0, 4'h0, 0, 0);

      // async reset mid-vector while B is on the output
      cyc(1, 1, 0, 16'hDCBA);
      chk_fwd("arst_a", 1, 1, 4'hA, 1, 0);
      cyc(0, 1, 0, 16'hDCBA);
      chk_fwd("arst_b", 0, 1, 4'hB, 0, 0);
      arst_n = 1'b0;
      #1;
      chk_fwd("arst_drop", 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      arst_n = 1'b1; load = 1'b0; sh_en = 1'b0;
      #1;
      chk_fwd("arst_idle", 0, 0, 4'h0, 0, 0);
      cyc(1, 0, 0, 16'hDCBA);
      chk_fwd("arst_reload", 1, 1, 4'hA, 1, 0);
      cyc(0, 0, 0, 16'h0000);
      chk_fwd("arst_hold", 0, 1, 4'hA, 1, 0);
      cyc(0, 1, 0, 16'h0000);
      cyc(0, 1, 0, 16'h0000);
      chk_fwd("arst_w1", 0, 1, 4'hB, 0, 0);
      cyc(0, 1, 0, 16'h0000);
      cyc(0, 1, 0, 16'h0000);
      chk_fwd("arst_w3", 0, 1, 4'hD, 0, 1);
      cyc(0, 0, 0, 16'h0000);
      chk_fwd("arst_end", 0, 0, 4'h0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
